// File: rtl/cpu_mem_port_if.sv
// Memory-bus bundle between the CPU memory port (master) and the memory arbiter (slave).
// The master holds req/we/addr/wdata stable until the arbiter acks; rdata is valid only alongside ack.
interface cpu_mem_port_if #(
    parameter int WORD_SIZE = 32
);
    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_mem_port.sv
// Memory-side front end of the multicycle CPU: owns IR, AR and flags and runs
// fetch / load / store / register-dump transactions over a variable-latency req/ack bus.
module cpu_mem_port #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FLAGS  = 2,
    parameter int DUMP_BASE  = 480,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fetch_req,
    input  logic                  load_req,
    input  logic                  store_req,
    input  logic                  dump_req,
    input  logic [WORD_SIZE-1:0]  pc,
    input  logic                  ar_write,
    input  logic [WORD_SIZE-1:0]  ar_din,
    input  logic [WORD_SIZE-1:0]  store_data,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [WORD_SIZE-1:0]  dump_data,
    input  logic [NUM_FLAGS-1:0]  flag_in,
    input  logic [NUM_FLAGS-1:0]  flag_write,
    output logic [NUM_FLAGS-1:0]  flags,
    output logic [WORD_SIZE-1:0]  ar,
    output logic [WORD_SIZE-1:0]  instr,
    output logic [WORD_SIZE-1:0]  load_data,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr,
    cpu_mem_port_if.master        bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DUMP  = 3'd4;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     TMO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [WORD_SIZE-1:0] DUMP_BASE_W = WORD_SIZE'(DUMP_BASE);

    logic [2:0]           state;
    logic [CNT_W-1:0]     tmo_cnt;
    logic                 ack_pending;
    logic [WORD_SIZE-1:0] ack_hold;
    logic [WORD_SIZE-1:0] instr_reg;
    logic [WORD_SIZE-1:0] addr_r;
    logic [WORD_SIZE-1:0] wdata_r;

    logic                 in_txn;
    logic                 ack_seen;
    logic [WORD_SIZE-1:0] rdata_eff;
    logic                 ack_capture;
    logic                 complete;
    logic                 timeout_hit;
    logic                 ar_locked;
    logic                 req_conflict;
    logic                 ar_conflict;
    logic                 err_set;

    assign in_txn      = (state != S_IDLE);
    assign ack_seen    = in_txn && (bus.mem_ack || ack_pending);
    assign rdata_eff   = ack_pending ? ack_hold : bus.mem_rdata;
    // An ack that lands during a stall is parked here and retired on the next enabled cycle.
    assign ack_capture = !en && in_txn && bus.mem_ack && !ack_pending;
    assign complete    = en && ack_seen;
    assign timeout_hit = en && in_txn && !ack_seen && (tmo_cnt == TMO_LAST);

    // AR feeds the bus address of loads/stores, so it is frozen while one is in flight.
    assign ar_locked    = (state == S_LOAD) || (state == S_STORE);
    assign req_conflict = en && (state == S_IDLE) &&
                          ($countones({fetch_req, load_req, store_req, dump_req}) > 1);
    assign ar_conflict  = en && ar_write && ar_locked;
    assign err_set      = req_conflict || ar_conflict || timeout_hit;

    assign busy          = in_txn;
    assign bus.mem_req   = in_txn;
    assign bus.mem_we    = (state == S_STORE) || (state == S_DUMP);
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign instr         = (state == S_FETCH && ack_seen) ? rdata_eff : instr_reg;

    always_ff @(posedge clk) begin
        if (ack_capture) ack_hold <= bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            ack_pending <= 1'b0;
            instr_reg   <= '0;
            load_data   <= '0;
            ar          <= '0;
            flags       <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
        end else begin
            done <= complete || timeout_hit;
            if (ack_capture) ack_pending <= 1'b1;

            if (en) begin
                for (int i = 0; i < NUM_FLAGS; i++) begin
                    if (flag_write[i]) flags[i] <= flag_in[i];
                end

                if (ar_write && !ar_locked) ar <= ar_din;

                if (err_set)      err <= 1'b1;
                else if (err_clr) err <= 1'b0;

                if (state == S_IDLE) begin
                    tmo_cnt <= '0;
                    if (fetch_req) begin
                        state  <= S_FETCH;
                        addr_r <= pc;
                    end else if (load_req) begin
                        state  <= S_LOAD;
                        addr_r <= ar;
                    end else if (store_req) begin
                        state   <= S_STORE;
                        addr_r  <= ar;
                        wdata_r <= store_data;
                    end else if (dump_req) begin
                        state   <= S_DUMP;
                        addr_r  <= DUMP_BASE_W + WORD_SIZE'(rd);
                        wdata_r <= dump_data;
                    end
                end else if (complete) begin
                    if (state == S_FETCH) instr_reg <= rdata_eff;
                    if (state == S_LOAD)  load_data <= rdata_eff;
                    state       <= S_IDLE;
                    tmo_cnt     <= '0;
                    ack_pending <= 1'b0;
                end else if (timeout_hit) begin
                    state   <= S_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_port.sv
// Scoreboard bench for cpu_mem_port: randomized transactions against a behavioural
// memory/register model, with a responder of random latency and random stalls.
module tb_cpu_mem_port;

    localparam int W   = 32;
    localparam int RW  = 5;
    localparam int NF  = 2;
    localparam int DB  = 480;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset, en;
    logic          fetch_req, load_req, store_req, dump_req;
    logic [W-1:0]  pc, ar_din, store_data, dump_data;
    logic          ar_write, err_clr;
    logic [RW-1:0] rd;
    logic [NF-1:0] flag_in, flag_write, flags;
    logic [W-1:0]  ar, instr, load_data;
    logic          done, busy, err;

    cpu_mem_port_if #(.WORD_SIZE(W)) bus ();

    cpu_mem_port #(
        .WORD_SIZE(W), .REG_ADDR_W(RW), .NUM_FLAGS(NF), .DUMP_BASE(DB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req), .dump_req(dump_req),
        .pc(pc), .ar_write(ar_write), .ar_din(ar_din), .store_data(store_data),
        .rd(rd), .dump_data(dump_data), .flag_in(flag_in), .flag_write(flag_write),
        .flags(flags), .ar(ar), .instr(instr), .load_data(load_data),
        .done(done), .busy(busy), .err(err), .err_clr(err_clr), .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_fetch;
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
        logic         noack;
        logic [W-1:0] exp_instr;
        logic [W-1:0] exp_load;
        logic [W-1:0] exp_ar;
        logic         exp_err;
    } item_t;

    item_t q[$];
    item_t mon_it;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0]  ref_mem[logic [W-1:0]];
    logic [W-1:0]  instr_m, load_m, ar_m;
    logic          err_m;
    logic [NF-1:0] flags_m;

    // Responder state
    logic [W-1:0] sl_mem[logic [W-1:0]];
    int           sl_lat;
    logic         sl_noack;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] dflt(logic [W-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [W-1:0] ref_rd(logic [W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [W-1:0] pick_addr();
        if ($urandom_range(0, 2) == 0) return W'(DB + int'($urandom_range(0, 31)));
        return W'(32'h40 + 4 * $urandom_range(0, 7));
    endfunction

    // One clock step: retire the flag update the edge just applied, then refresh flag stimulus.
    task automatic tick();
        @(posedge clk);
        if (reset) flags_m = '0;
        else if (en) begin
            for (int i = 0; i < NF; i++) if (flag_write[i]) flags_m[i] = flag_in[i];
        end
        #1;
        flag_in    = NF'($urandom);
        flag_write = NF'($urandom);
    endtask

    // Memory responder: acks once per transaction after sl_lat request cycles, regardless of en.
    initial begin
        int   wait_cnt;
        logic acked;
        wait_cnt      = 0;
        acked         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (!bus.mem_req || reset) begin
                acked    = 1'b0;
                wait_cnt = sl_lat;
            end else if (!acked && !sl_noack) begin
                if (wait_cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    acked       = 1'b1;
                    if (bus.mem_we) sl_mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = sl_mem.exists(bus.mem_addr) ? sl_mem[bus.mem_addr]
                                                                     : dflt(bus.mem_addr);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: bus checks while a request is up, full scoreboard compare on every done pulse.
    initial begin
        int   en_cnt;
        logic en_last;
        en_cnt  = 0;
        en_last = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                en_cnt = 0;
            end else begin
                chk("flags", W'(flags), W'(flags_m));
                if (bus.mem_req) begin
                    if (q.size() == 0) chk("unexpected_req", W'(bus.mem_req), 0);
                    else begin
                        mon_it = q[0];
                        chk("busy", W'(busy), 1);
                        chk("mem_addr", bus.mem_addr, mon_it.addr);
                        chk("mem_we", W'(bus.mem_we), W'(mon_it.we));
                        if (mon_it.we) chk("mem_wdata", bus.mem_wdata, mon_it.wdata);
                        if (bus.mem_ack && mon_it.is_fetch) chk("instr_comb", instr, bus.mem_rdata);
                        if (en && !bus.mem_ack) en_cnt++;
                    end
                end
                if (done) begin
                    if (q.size() == 0) chk("unexpected_done", W'(done), 0);
                    else begin
                        mon_it = q.pop_front();
                        chk("done_after_en", W'(en_last), 1);
                        chk("req_after_done", W'(bus.mem_req), 0);
                        chk("busy_after_done", W'(busy), 0);
                        chk("instr", instr, mon_it.exp_instr);
                        chk("load_data", load_data, mon_it.exp_load);
                        chk("ar", ar, mon_it.exp_ar);
                        chk("err", W'(err), W'(mon_it.exp_err));
                        if (mon_it.noack) chk("timeout_cycles", W'(en_cnt), W'(TMO));
                    end
                    en_cnt = 0;
                end
            end
            en_last = en;
        end
    end

    // Issue one transaction from an idle cycle and wait for its done pulse.
    // Request mask bits: [3]=fetch [2]=load [1]=store [0]=dump.
    task automatic run_txn(input logic [3:0] mf, input int lat, input int na, input bit stall_ok,
                           input int frd, input int fpc, output int ncyc);
        logic [3:0] m;
        int         k;
        item_t      it;
        logic       noack;
        if (mf != 4'b0)                     m = mf;
        else if ($urandom_range(0, 7) == 0) m = 4'($urandom_range(3, 15));
        else                                m = 4'b0001 << $urandom_range(0, 3);
        k = m[3] ? 0 : m[2] ? 1 : m[1] ? 2 : 3;
        noack    = (na >= 0) ? (na != 0) : ($urandom_range(0, 7) == 0);
        sl_noack = noack;
        sl_lat   = (lat >= 0) ? lat : int'($urandom_range(0, 3));
        pc         = (fpc >= 0) ? W'(fpc) : pick_addr();
        rd         = (frd >= 0) ? RW'(frd) : RW'($urandom);
        store_data = $urandom;
        dump_data  = $urandom;

        it.is_fetch = (k == 0);
        it.noack    = noack;
        it.wdata    = '0;
        case (k)
            0:       begin it.addr = pc;   it.we = 1'b0; end
            1:       begin it.addr = ar_m; it.we = 1'b0; end
            2:       begin it.addr = ar_m; it.we = 1'b1; it.wdata = store_data; end
            default: begin it.addr = W'(DB) + W'(rd); it.we = 1'b1; it.wdata = dump_data; end
        endcase

        {fetch_req, load_req, store_req, dump_req} = m;
        en      = 1'b1;
        err_clr = ($urandom_range(0, 3) == 0);
        if ($countones(m) > 1) err_m = 1'b1;
        else if (err_clr)      err_m = 1'b0;
        ar_write = ($urandom_range(0, 3) == 0);
        ar_din   = pick_addr();
        if (ar_write) ar_m = ar_din;
        tick();
        ncyc = 1;

        // First request cycle: stray requests are ignored, AR writes are checked against the lock.
        {fetch_req, load_req, store_req, dump_req} = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
        err_clr  = 1'b0;
        ar_write = ($urandom_range(0, 2) == 0);
        ar_din   = pick_addr();
        if (ar_write) begin
            if (k == 1 || k == 2) err_m = 1'b1;
            else                  ar_m  = ar_din;
        end
        if (noack) err_m = 1'b1;
        else begin
            case (k)
                0:       instr_m = ref_rd(pc);
                1:       load_m  = ref_rd(it.addr);
                default: ref_mem[it.addr] = it.wdata;
            endcase
        end
        it.exp_instr = instr_m;
        it.exp_load  = load_m;
        it.exp_ar    = ar_m;
        it.exp_err   = err_m;
        q.push_back(it);
        tick();
        ncyc = 2;
        {fetch_req, load_req, store_req, dump_req} = 4'b0;
        ar_write = 1'b0;
        while (!done) begin
            if (ncyc >= 80) begin
                chk("done_wait", W'(done), 1);
                break;
            end
            en = stall_ok ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick();
            ncyc++;
        end
        en = 1'b1;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        en      = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m   = 1'b0;
        chk("err_clr", W'(err), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        item_t it;
        reset = 1'b1; en = 1'b0;
        fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0; dump_req = 1'b0;
        pc = '0; ar_din = '0; store_data = '0; dump_data = '0; rd = '0;
        ar_write = 1'b0; err_clr = 1'b0; flag_in = '0; flag_write = '0;
        sl_lat = 0; sl_noack = 1'b0;
        flags_m = '0; ar_m = '0; instr_m = '0; load_m = '0; err_m = 1'b0;
        repeat (3) tick();

        chk("rst_ar", ar, 0);
        chk("rst_instr", instr, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_flags", W'(flags), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_err", W'(err), 0);
        chk("rst_mem_req", W'(bus.mem_req), 0);
        chk("rst_mem_we", W'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);

        reset = 1'b0;
        en    = 1'b1;
        tick();

        // Fetch with zero-delay ack: done two cycles after the request, IR holds afterwards.
        ref_mem[32'h10] = 32'h00A00093;
        sl_mem[32'h10]  = 32'h00A00093;
        run_txn(4'b1000, 0, 0, 1'b0, -1, 32'h10, n);
        chk("fetch_latency", W'(n), 2);
        tick();
        chk("instr_hold", instr, 32'h00A00093);

        // Dump of the top register wraps to the end of the dump region.
        run_txn(4'b0001, 2, 0, 1'b0, 31, -1, n);
        chk("dump_top_addr", W'(DB) + W'(31), 32'd511);

        // Load that never gets an ack aborts with err and leaves load_data alone.
        run_txn(4'b0100, 0, 1, 1'b0, -1, -1, n);
        clear_err();

        // Fetch and load in the same cycle: fetch is served, err is raised.
        run_txn(4'b1100, 1, 0, 1'b0, -1, -1, n);
        clear_err();

        for (int t = 0; t < 300; t++) begin
            run_txn(4'b0, -1, -1, 1'b1, -1, -1, n);
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        // Reset in the middle of a load drops the bus request and clears AR.
        ar_write = 1'b1; ar_din = 32'h40; en = 1'b1;
        tick();
        ar_write = 1'b0; ar_m = 32'h40;
        sl_noack = 1'b1;
        it.is_fetch = 1'b0; it.addr = 32'h40; it.we = 1'b0; it.wdata = '0; it.noack = 1'b1;
        it.exp_instr = instr_m; it.exp_load = load_m; it.exp_ar = ar_m; it.exp_err = err_m;
        q.push_back(it);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        ar_m = '0; instr_m = '0; load_m = '0; err_m = 1'b0;
        chk("midrst_mem_req", W'(bus.mem_req), 0);
        chk("midrst_busy", W'(busy), 0);
        chk("midrst_ar", ar, 0);
        chk("midrst_done", W'(done), 0);
        chk("midrst_mem_addr", bus.mem_addr, 0);

        for (int t = 0; t < 20; t++) run_txn(4'b0, -1, -1, 1'b1, -1, -1, n);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_port.md
Name: cpu_mem_port

Overview:
- Memory-side front end of the multicycle CPU, generalised from the current core wiring.
- Owns the instruction register, address register (AR) and a parametrised flag register.
- Runs instruction fetch, data load/store and register-dump (VGA text) writes over a variable-latency req/ack memory bus.
- Sits between the controller/datapath and the memory arbiter. Adds the wait-state handshake, ack buffering under stall, and a timeout with error reporting.

Parameters:
WORD_SIZE, 32, data/address width
REG_ADDR_W, 5, register index width
NUM_FLAGS, 2, condition flag count (bit0 zero, bit1 lt)
DUMP_BASE, 480, base address of register-dump region
TIMEOUT, 255, max cycles waiting for mem_ack before abort (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  global step enable; low = stall
fetch_req  in  1  fetch instruction at pc
load_req  in  1  read word at ar
store_req  in  1  write store_data at ar
dump_req  in  1  write dump_data at DUMP_BASE+rd
pc  in  WORD_SIZE  program counter
ar_write  in  1  load AR from ar_din
ar_din  in  WORD_SIZE  ALU result
store_data  in  WORD_SIZE  store payload
rd  in  REG_ADDR_W  dumped register index
dump_data  in  WORD_SIZE  dumped register value
flag_in  in  NUM_FLAGS  new flag values
flag_write  in  NUM_FLAGS  per-flag write enable
flags  out  NUM_FLAGS  registered flags
ar  out  WORD_SIZE  address register
instr  out  WORD_SIZE  current instruction
load_data  out  WORD_SIZE  last loaded word
done  out  1  one-cycle completion pulse
busy  out  1  transaction in progress
err  out  1  sticky error
err_clr  in  1  clears err
mem_req  out  1  bus request
mem_we  out  1  write strobe, valid with mem_req
mem_addr  out  WORD_SIZE  bus address
mem_wdata  out  WORD_SIZE  bus write data
mem_rdata  in  WORD_SIZE  bus read data, valid with mem_ack
mem_ack  in  1  bus completion

Behaviour:
- Reset: state IDLE, ar=0, instr_reg=0, load_data=0, flags=0, err=0, timeout counter=0, ack_pending=0. Outputs done, busy, mem_req, mem_we are 0; mem_addr and mem_wdata are 0. A reset mid-transaction aborts it; mem_req is 0 from the next edge.
- Stall gating: all register updates, state transitions and counting occur only when en=1. Exceptions: reset, and mem_ack capture.
- mem_ack arriving while en=0 (with mem_req=1) sets ack_pending and captures mem_rdata into a hold register. The transaction completes on the first en=1 cycle. An ack is never lost.
- FSM states: IDLE, FETCH, LOAD, STORE, DUMP.
- IDLE with en=1: accept one request. Priority is fetch > load > store > dump; lower-priority requests in the same cycle are dropped and set err.
- On accept: busy=1 and mem_req=1 from the next cycle. Addresses:
  - FETCH: mem_addr=pc sampled at accept.
  - LOAD/STORE: mem_addr=ar.
  - DUMP: mem_addr=DUMP_BASE+rd, modulo 2^WORD_SIZE.
  - mem_we=1 for STORE/DUMP; mem_wdata=store_data or dump_data sampled at accept.
- mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack cycle.
- Completion, on an ack cycle with en=1 (or ack_pending):
  - FETCH writes instr_reg; LOAD writes load_data.
  - done=1 for one cycle; return to IDLE; busy=0 next cycle; mem_req=0 next cycle.
  - Minimum latency request to done is 2 cycles (ack in the first mem_req cycle).
- instr = mem_rdata combinationally during the FETCH ack cycle, else instr_reg.
- Timeout: the counter increments each en=1 cycle with mem_req=1 and no ack. When it reaches TIMEOUT:
  - abort: err=1, done=1, no register capture, return to IDLE;
  - instr_reg and load_data are unchanged.
- AR: ar_write with en=1 loads ar_din when in IDLE. During LOAD/STORE it is ignored and sets err, so the address stays stable. During FETCH/DUMP it is allowed.
- Flags: for each i, flags[i] <= flag_in[i] when flag_write[i]=1 and en=1. Independent of FSM state.
- err: sticky; err_clr with en=1 clears it. A same-cycle set wins over the clear.
- A request asserted while busy is ignored and does not queue.

Test Plan:
- Fetch, ack delay 0: pc=0x10, fetch_req 1 cycle, mem_ack in first req cycle with rdata=0x00A00093 -> mem_addr=0x10, mem_we=0, instr=0x00A00093 same cycle, done 2 cycles after request, instr_reg holds after.
- Store then load, ack delay 3: ar_write ar_din=0x40; store_req store_data=0xDEADBEEF -> mem_we=1, addr 0x40, data held 4 cycles. load_req with rdata=0xDEADBEEF -> load_data=0xDEADBEEF, one done pulse each.
- Dump: rd=5, dump_data=0x1234 -> mem_addr=485, mem_wdata=0x1234, mem_we=1. rd=31 -> addr 511.
- Stall: en=0 asserted while mem_req=1, mem_ack pulses 1 cycle -> no done while en=0. en=1 -> done next cycle with captured rdata.
- Timeout: TIMEOUT=4, no ack -> done+err after 4 en cycles, load_data unchanged. err_clr -> err=0.
- Conflicts: fetch_req+load_req same cycle -> fetch served, err=1. ar_write during LOAD -> ar unchanged, err=1. Reset mid-LOAD -> mem_req=0, busy=0, ar=0 next cycle.
